// File: rtl/key_pkg.sv
// key_pkg: shared types and default constants for the push-button debouncer.
//   key_st_e     : per-key debounce FSM state encoding
//   *_DEF        : default tick divider, debounce and long-press lengths
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } key_st_e;

  localparam int TICK_DIV_DEF = 50000;  // 1 ms at 50 MHz
  localparam int DB_MS_DEF    = 20;
  localparam int LONG_MS_DEF  = 1000;

endpackage

// File: rtl/key_fsm.sv
// key_fsm: one button's synchroniser, debounce FSM, tick counter and pulses.
// Optional long-press detection is built when KEY_LONG_PRESS_EN is defined.
//   sys_clk, sys_rst : clock, async active-high reset
//   tick             : shared debounce tick (one cycle wide)
//   key_pin          : raw active-low pin
//   key_state        : debounced level, 1 = pressed
//   key_press        : one-cycle pulse on accepted press
//   key_release      : one-cycle pulse on accepted release
//   key_long         : one-cycle pulse after LONG_MS ticks held (0 if disabled)
module key_fsm
  import key_pkg::*;
#(
  parameter int DB_MS   = DB_MS_DEF,
  parameter int LONG_MS = LONG_MS_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic tick,
  input  logic key_pin,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int CW = $clog2(LONG_MS + 1);
  localparam logic [CW-1:0] DB_END = CW'(DB_MS);

  // Two-flop synchroniser; resets to the released pin level.
  logic [1:0] sync;
  logic       key_s;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) sync <= 2'b11;
    else         sync <= {sync[0], key_pin};
  end

  assign key_s = ~sync[1];

  key_st_e       state, state_nxt;
  logic [CW-1:0] db_cnt, cnt_nxt, cnt_inc;
  logic          press_nxt, rel_nxt;

  // Saturating increment: the counter never wraps.
  assign cnt_inc = (&db_cnt) ? db_cnt : db_cnt + 1'b1;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_END = CW'(LONG_MS);
  logic long_nxt;
`endif

  // A level change on key_s is checked before tick, so a bounce coinciding
  // with a tick discards the count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = db_cnt;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
`ifdef KEY_LONG_PRESS_EN
    long_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (key_s) begin
          state_nxt = PRESS_DB;
          cnt_nxt   = '0;
        end
      end
      PRESS_DB: begin
        if (!key_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (tick) begin
          if (cnt_inc == DB_END) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_nxt = RELEASE_DB;
          cnt_nxt   = '0;
        end
`ifdef KEY_LONG_PRESS_EN
        // Hold count reuses db_cnt; it saturates so the pulse fires once.
        else if (tick) begin
          cnt_nxt  = cnt_inc;
          long_nxt = (cnt_inc == LONG_END) && (db_cnt != LONG_END);
        end
`endif
      end
      RELEASE_DB: begin
        if (key_s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (tick) begin
          if (cnt_inc == DB_END) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            rel_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      db_cnt      <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      db_cnt      <= cnt_nxt;
      key_press   <= press_nxt;
      key_release <= rel_nxt;
    end
  end

`ifdef KEY_LONG_PRESS_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) key_long <= 1'b0;
    else         key_long <= long_nxt;
  end
`else
  assign key_long = 1'b0;
`endif

  assign key_state = (state == PRESSED) || (state == RELEASE_DB);

endmodule

// File: rtl/key_debounce.sv
// key_debounce: debounces KEY_NUM active-low buttons against a shared tick.
// Long-press pulses are built when KEY_LONG_PRESS_EN is defined.
//   sys_clk, sys_rst : clock, async active-high reset
//   key_in           : raw active-low pins
//   key_state        : debounced levels, 1 = pressed
//   key_press        : one-cycle press pulses
//   key_release      : one-cycle release pulses
//   key_code         : registered index of lowest pressed key (0 if none)
//   key_valid        : registered OR of key_state
//   key_long         : one-cycle long-press pulses (0 if disabled)
module key_debounce
  import key_pkg::*;
#(
  parameter int KEY_NUM  = 4,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DB_MS    = DB_MS_DEF,
  parameter int LONG_MS  = LONG_MS_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [2:0]         key_code,
  output logic               key_valid,
  output logic [KEY_NUM-1:0] key_long
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) tick_cnt <= '0;
    else         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_key
    key_fsm #(
      .DB_MS   (DB_MS),
      .LONG_MS (LONG_MS)
    ) u_key (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .tick        (tick),
      .key_pin     (key_in[gi]),
      .key_state   (key_state[gi]),
      .key_press   (key_press[gi]),
      .key_release (key_release[gi]),
      .key_long    (key_long[gi])
    );
  end

  // Priority encoder: scanning downward leaves the lowest set index.
  logic [2:0] code_nxt;

  always_comb begin
    code_nxt = 3'd0;
    for (int i = KEY_NUM - 1; i >= 0; i--)
      if (key_state[i]) code_nxt = 3'(i);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      key_code  <= 3'd0;
      key_valid <= 1'b0;
    end else begin
      key_code  <= code_nxt;
      key_valid <= |key_state;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;
  localparam int KN = 4, TD = 10, DB = 3, LM = 8;

  logic          sys_clk = 1'b0, sys_rst = 1'b1;
  logic [KN-1:0] key_in = '1;
  logic [KN-1:0] key_state, key_press, key_release, key_long;
  logic [2:0]    key_code;
  logic          key_valid;

  key_debounce #(.KEY_NUM(KN), .TICK_DIV(TD), .DB_MS(DB), .LONG_MS(LM)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_in(key_in),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .key_code(key_code), .key_valid(key_valid), .key_long(key_long));

  always #5 sys_clk = ~sys_clk;

  int total = 0, bad = 0;

  // Reference model: each key holds an accepted level and, while the
  // synchronised pin disagrees, a candidate that must survive DB ticks.
  int            m_tcnt, m_n[KN], m_h[KN];
  logic [KN-1:0] m_s1, m_s2, m_acc, m_pend, m_press, m_rel, m_long;
  logic [2:0]    m_code;
  logic          m_valid;

  // Observation
  int            cyc_no, lock_err, mpcnt;
  int            pcnt[KN], rcnt[KN], lcnt[KN], pcyc[KN], lcyc[KN];
  logic [KN-1:0] st_seen;

  task automatic model_step();
    bit tk;
    logic [KN-1:0] ks;
    if (sys_rst) begin
      m_tcnt = 0; m_s1 = '1; m_s2 = '1; m_acc = '0; m_pend = '0;
      m_press = '0; m_rel = '0; m_long = '0; m_code = 0; m_valid = 0;
      for (int i = 0; i < KN; i++) begin m_n[i] = 0; m_h[i] = 0; end
      return;
    end
    tk = (m_tcnt == TD - 1);
    m_tcnt = tk ? 0 : m_tcnt + 1;
    ks = ~m_s2; m_s2 = m_s1; m_s1 = key_in;
    m_valid = |m_acc;
    m_code = 0;
    for (int i = KN - 1; i >= 0; i--) if (m_acc[i]) m_code = 3'(i);
    m_press = '0; m_rel = '0; m_long = '0;
    for (int i = 0; i < KN; i++) begin
      if (!m_pend[i]) begin
        if (ks[i] != m_acc[i]) begin
          m_pend[i] = 1'b1; m_n[i] = 0; m_h[i] = 0;
        end else if (m_acc[i] && tk && m_h[i] < LM) begin
          m_h[i]++;
          if (m_h[i] == LM) m_long[i] = 1'b1;
        end
      end else if (ks[i] == m_acc[i]) begin
        m_pend[i] = 1'b0;
      end else if (tk) begin
        m_n[i]++;
        if (m_n[i] == DB) begin
          m_acc[i] = ks[i]; m_pend[i] = 1'b0; m_h[i] = 0;
          if (ks[i]) m_press[i] = 1'b1; else m_rel[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic clr_obs();
    lock_err = 0; mpcnt = 0; st_seen = '0; cyc_no = 0;
    for (int i = 0; i < KN; i++) begin
      pcnt[i] = 0; rcnt[i] = 0; lcnt[i] = 0; pcyc[i] = -1; lcyc[i] = -1;
    end
  endtask

  task automatic cyc(input int n);
    logic [KN-1:0] exp_long;
    repeat (n) begin
      model_step();
      @(posedge sys_clk); #1;
      cyc_no++;
`ifdef KEY_LONG_PRESS_EN
      exp_long = m_long;
`else
      exp_long = '0;
`endif
      if ({key_state, key_press, key_release, key_long, key_code, key_valid} !==
          {m_acc, m_press, m_rel, exp_long, m_code, m_valid}) lock_err++;
      st_seen |= key_state;
      for (int i = 0; i < KN; i++) begin
        if (m_press[i]) mpcnt++;
        if (key_press[i] === 1'b1) begin pcnt[i]++; if (pcyc[i] < 0) pcyc[i] = cyc_no; end
        if (key_release[i] === 1'b1) rcnt[i]++;
        if (key_long[i] === 1'b1) begin lcnt[i]++; if (lcyc[i] < 0) lcyc[i] = cyc_no; end
      end
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; key_in = '0;
    clr_obs(); cyc(5);
    total++;
    if ({key_state, key_press, key_release, key_long, key_code, key_valid} !== 20'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0",
        {key_state, key_press, key_release, key_long, key_code, key_valid});
    end
    sys_rst = 1'b0; clr_obs(); cyc(40);
    for (int i = 0; i < KN; i++) begin
      total++;
      if (pcnt[i] !== 1 || pcyc[i] !== DB * TD) begin
        bad++; $display("FAIL reset_repress[%0d]: got count=%0d cyc=%0d want 1 at %0d",
                        i, pcnt[i], pcyc[i], DB * TD);
      end
    end
    total++;
    if (lock_err !== 0) begin bad++; $display("FAIL reset_model: got %0d mismatching cycles want 0", lock_err); end
    key_in = '1; cyc(50);
  endtask

  task automatic test_clean_press();
    cyc($urandom_range(0, TD - 1));
    key_in[1] = 1'b0; clr_obs(); cyc(100);
    total++;
    if (pcnt[1] !== 1 || pcyc[1] < (DB - 1) * TD + 4 || pcyc[1] > DB * TD + 3) begin
      bad++; $display("FAIL press_latency: got count=%0d cyc=%0d want 1 in [%0d,%0d]",
                      pcnt[1], pcyc[1], (DB - 1) * TD + 4, DB * TD + 3);
    end
    total++;
    if ({key_state, key_code, key_valid} !== {4'b0010, 3'd1, 1'b1}) begin
      bad++; $display("FAIL press_level: got state=%b code=%0d valid=%b want 0010/1/1",
                      key_state, key_code, key_valid);
    end
    key_in = '1; cyc(60);
    total++;
    if (rcnt[1] !== 1 || key_state !== 4'b0000 || key_valid !== 1'b0) begin
      bad++; $display("FAIL release: got rel=%0d state=%b valid=%b want 1/0000/0",
                      rcnt[1], key_state, key_valid);
    end
    total++;
    if (lock_err !== 0) begin bad++; $display("FAIL press_model: got %0d mismatching cycles want 0", lock_err); end
  endtask

  task automatic test_bounce();
    clr_obs();
    for (int k = 0; k < 13; k++) begin key_in[0] = ~key_in[0]; cyc(15); end
    key_in = '1; cyc(10);
    total++;
    if (pcnt[0] !== 0 || rcnt[0] !== 0 || st_seen[0] !== 1'b0) begin
      bad++; $display("FAIL bounce: got press=%0d rel=%0d state_seen=%b want 0/0/0",
                      pcnt[0], rcnt[0], st_seen[0]);
    end
    total++;
    if (lock_err !== 0) begin bad++; $display("FAIL bounce_model: got %0d mismatching cycles want 0", lock_err); end
  endtask

  task automatic test_simultaneous();
    clr_obs();
    key_in = 4'b0011; cyc(40);
    total++;
    if (pcnt[2] !== 1 || pcnt[3] !== 1 || pcyc[2] !== pcyc[3]) begin
      bad++; $display("FAIL simul_press: got cnt=%0d/%0d cyc=%0d/%0d want 1/1 same cycle",
                      pcnt[2], pcnt[3], pcyc[2], pcyc[3]);
    end
    total++;
    if (key_code !== 3'd2) begin bad++; $display("FAIL simul_code: got %0d want 2", key_code); end
    key_in[2] = 1'b1; cyc(40);
    total++;
    if (key_code !== 3'd3 || key_state !== 4'b1000 || rcnt[2] !== 1) begin
      bad++; $display("FAIL simul_release: got code=%0d state=%b rel=%0d want 3/1000/1",
                      key_code, key_state, rcnt[2]);
    end
    key_in = '1; cyc(50);
    total++;
    if (lock_err !== 0) begin bad++; $display("FAIL simul_model: got %0d mismatching cycles want 0", lock_err); end
  endtask

  task automatic test_reset_mid_hold();
    key_in[0] = 1'b0; cyc(40);
    total++;
    if (key_state[0] !== 1'b1) begin bad++; $display("FAIL hold_state: got %b want 1", key_state[0]); end
    clr_obs();
    sys_rst = 1'b1; cyc(5);
    total++;
    if (key_state !== 4'b0000 || key_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_state: got %b/%b want 0000/0", key_state, key_valid);
    end
    sys_rst = 1'b0; cyc_no = 0; cyc(40);
    total++;
    if (rcnt[0] !== 0 || pcnt[0] !== 1 || pcyc[0] !== DB * TD) begin
      bad++; $display("FAIL midreset_repress: got rel=%0d press=%0d cyc=%0d want 0/1/%0d",
                      rcnt[0], pcnt[0], pcyc[0], DB * TD);
    end
    key_in = '1; cyc(50);
    total++;
    if (lock_err !== 0) begin bad++; $display("FAIL midreset_model: got %0d mismatching cycles want 0", lock_err); end
  endtask

  task automatic test_long_press();
    clr_obs();
    key_in[1] = 1'b0; cyc(150);
    total++;
`ifdef KEY_LONG_PRESS_EN
    if (pcnt[1] !== 1 || lcnt[1] !== 1 || lcyc[1] - pcyc[1] !== LM * TD) begin
      bad++; $display("FAIL long_press: got press=%0d long=%0d gap=%0d want 1/1/%0d",
                      pcnt[1], lcnt[1], lcyc[1] - pcyc[1], LM * TD);
    end
`else
    if (pcnt[1] !== 1 || lcnt[1] !== 0) begin
      bad++; $display("FAIL long_off: got press=%0d long=%0d want 1/0", pcnt[1], lcnt[1]);
    end
`endif
    key_in = '1; cyc(50);
    total++;
    if (lock_err !== 0) begin bad++; $display("FAIL long_model: got %0d mismatching cycles want 0", lock_err); end
  endtask

  task automatic test_random();
    int dut_p;
    clr_obs();
    for (int s = 0; s < 60; s++) begin
      if (s == 30) begin sys_rst = 1'b1; cyc($urandom_range(1, 4)); sys_rst = 1'b0; end
      key_in = KN'($urandom);
      cyc($urandom_range(1, 45));
    end
    key_in = '1; cyc(50);
    dut_p = 0;
    for (int i = 0; i < KN; i++) dut_p += pcnt[i];
    total++;
    if (dut_p !== mpcnt) begin bad++; $display("FAIL random_presses: got %0d want %0d", dut_p, mpcnt); end
    total++;
    if (lock_err !== 0) begin bad++; $display("FAIL random_model: got %0d mismatching cycles want 0", lock_err); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_hold();
    test_long_press();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounces and edge-detects the board's active-low push buttons for FuncTest. It is the input-side counterpart of the LED display driver. Raw pins are synchronised to `sys_clk`, filtered against a shared millisecond tick, and presented as a stable level, one-cycle press/release pulses and a priority-encoded key code for downstream test logic.

## Interface
- `KEY_NUM`, 4: number of buttons (1–8).
- `TICK_DIV`, 50000: `sys_clk` cycles per debounce tick (1 ms at 50 MHz).
- `DB_MS`, 20: consecutive stable ticks required to accept a level change.
- `LONG_MS`, 1000: ticks held before a long-press pulse. Used only when `KEY_LONG_PRESS_EN` is defined.
- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `key_in`  in  KEY_NUM  raw button pins, active-low (0 = pressed), asynchronous.
- `key_state`  out  KEY_NUM  debounced level, 1 = pressed; reset 0.
- `key_press`  out  KEY_NUM  one-cycle pulse on accepted press; reset 0.
- `key_release`  out  KEY_NUM  one-cycle pulse on accepted release; reset 0.
- `key_code`  out  3  index of the lowest-numbered key currently in `key_state`; reset 0.
- `key_valid`  out  1  OR of `key_state`; reset 0.
- `key_long`  out  KEY_NUM  one-cycle long-press pulse; reset 0; tied 0 when the macro is off.

## Operation
- Synchroniser: two flops per key, reset to 1 (released). The value `key_s = ~sync2` is the active-high synchronised level.
- Tick generator:
  - counter 0..TICK_DIV-1; `tick` is high for one cycle when the counter equals TICK_DIV-1, then wraps to 0.
  - shared by all keys.
- Per-key FSM with states IDLE, PRESS_DB, PRESSED, RELEASE_DB. Per-key tick counter `db_cnt`, width clog2(LONG_MS+1).
  - IDLE: if `key_s`=1, go to PRESS_DB and clear `db_cnt`.
  - PRESS_DB: if `key_s`=0, return to IDLE (bounce rejected, no pulse). Otherwise, on `tick`, increment `db_cnt`. On the tick where `db_cnt` reaches DB_MS: go to PRESSED, pulse `key_press`, clear `db_cnt`.
  - PRESSED: if `key_s`=0, go to RELEASE_DB and clear `db_cnt`.
  - RELEASE_DB: mirror of PRESS_DB. If `key_s`=1, return to PRESSED. When the count completes: go to IDLE and pulse `key_release`.
  - On simultaneous bounce and `tick`, the bounce wins: the count is discarded.
- `key_state`:
  - 1 in PRESSED and RELEASE_DB.
  - 0 in IDLE and PRESS_DB.
- Encoder:
  - `key_code` = lowest index i with `key_state[i]`=1.
  - When `key_valid`=0, `key_code` holds 0.
  - Registered, so it is one cycle behind `key_state`.
- Multiple keys may press or release in the same cycle; each key's pulse is independent.
- `db_cnt` saturates at its maximum and never wraps.

## Timing
- Pin to `key_s`: 2 cycles.
- `key_s` change to debounce-state entry: 1 cycle.
- Press latency: DB_MS ticks after PRESS_DB entry. This is (DB_MS-1)·TICK_DIV+1 to DB_MS·TICK_DIV cycles, depending on tick phase.
- `key_press`, `key_state` rise and FSM entry to PRESSED all occur on the same clock edge. `key_code` and `key_valid` follow one cycle later.
- Release timing is symmetric.
- Reset asserted mid-debounce or mid-hold:
  - all FSMs return to IDLE, counters clear, outputs return to 0.
  - no pulses are emitted during or on exit from reset.
- If a key is held through reset release, it is re-debounced: `key_press` fires DB_MS ticks later.

## Configuration
- `KEY_LONG_PRESS_EN` defined:
  - in PRESSED, `db_cnt` increments on `tick`.
  - when it reaches LONG_MS, `key_long` pulses once per hold. The counter then saturates, so there is no repeat.
  - the counter clears on leaving PRESSED, so a return from RELEASE_DB restarts the hold count.
- Not defined: no hold counting; `key_long` is constant 0.

## Structure
- Package `key_pkg`:
  - FSM state encoding: IDLE=2'd0, PRESS_DB=2'd1, PRESSED=2'd2, RELEASE_DB=2'd3.
  - default TICK_DIV, DB_MS and LONG_MS constants.
- Sub-module `key_fsm`: one key's synchroniser, FSM, `db_cnt` and pulse outputs. It takes the shared `tick` as input and is instantiated KEY_NUM times in a generate loop.
- The top level holds the tick generator and the priority encoder.

## Test plan
All scenarios use TICK_DIV=10, DB_MS=3, LONG_MS=8, KEY_NUM=4.
- Reset: hold `sys_rst`=1 with `key_in`=4'b0000 → all outputs 0. After release, `key_press[3:0]` pulses once, 3 ticks later.
- Clean press of `key_in[1]` held low 100 cycles → one `key_press[1]` pulse within 21–30 cycles of the pin edge, plus 3 cycles of sync/entry. Then `key_state`=4'b0010, `key_code`=1, `key_valid`=1.
- Bounce: toggle `key_in[0]` every 15 cycles for 200 cycles → no pulses; `key_state[0]` stays 0.
- Simultaneous: press keys 2 and 3 in the same cycle → both press pulses in the same cycle; `key_code`=2. Release key 2 → `key_code`=3.
- Reset mid-hold: key 0 in PRESSED, assert `sys_rst` for 5 cycles → `key_state`=0 and no `key_release` pulse. Key 0 re-presses after 3 ticks.
- `KEY_LONG_PRESS_EN`: hold key 1 for 150 cycles → exactly one `key_long[1]` pulse, 8 ticks after `key_press[1]`. Macro off → `key_long` stays 0.
